// File: rtl/port_arbiter5.sv
// ---------------------------------------------------------------------------
// port_arbiter5
//
// Round-robin arbiter that shares one peripheral port among five masters.
// One master owns the port at a time. Every change of owner is separated by
// one all-zero grant cycle. A watchdog revokes a grant that has been held for
// TIMEOUT cycles. The revoked master is then masked until it drops its request.
//
// Parameters
//   TIMEOUT      maximum owned cycles per grant (2..255)
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   req[4:0]     request lines, bit i held high by master i
//   gnt[4:0]     registered one-hot grant, or all zero
//   gnt_id[2:0]  registered index of the owner, valid while busy=1
//   busy         registered, high while any gnt bit is high
//   timeout_err  registered one-cycle pulse when a grant is revoked
// ---------------------------------------------------------------------------
module port_arbiter5 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [2:0] ptr, ptr_next;
  logic [4:0] mask, mask_next;
  logic [7:0] cnt, cnt_next;
  logic [4:0] gnt_next;
  logic [2:0] gnt_id_next;
  logic       busy_next;
  logic       timeout_err_next;

  logic [4:0] eligible;
  logic       found;
  logic [2:0] winner;
  logic [3:0] scan;

  // Rotating priority scan. The search starts at ptr and wraps modulo 5.
  // The first eligible index wins. Masked masters are never eligible.
  always_comb begin
    eligible = req & ~mask;
    found    = 1'b0;
    winner   = 3'd0;
    scan     = 4'd0;
    for (int k = 0; k < 5; k++) begin
      scan = {1'b0, ptr} + 4'(k);
      if (scan >= 4'd5) scan = scan - 4'd5;
      if (!found && eligible[scan[2:0]]) begin
        found  = 1'b1;
        winner = scan[2:0];
      end
    end
  end

  // Next-state and next-output logic.
  // A mask bit clears whenever its request is low, in every state.
  // In OWN, a request drop is checked before the timeout. A drop on the
  // timeout edge is therefore an ordinary release.
  always_comb begin
    state_next       = state;
    ptr_next         = ptr;
    mask_next        = mask & req;
    cnt_next         = cnt;
    gnt_next         = gnt;
    gnt_id_next      = gnt_id;
    busy_next        = busy;
    timeout_err_next = 1'b0;

    case (state)
      IDLE, GAP: begin
        if (found) begin
          gnt_next    = 5'b00001 << winner;
          gnt_id_next = winner;
          busy_next   = 1'b1;
          ptr_next    = (winner == 3'd4) ? 3'd0 : winner + 3'd1;
          cnt_next    = 8'd1;
          state_next  = OWN;
        end else begin
          gnt_next   = 5'b00000;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      OWN: begin
        if (!req[gnt_id]) begin
          gnt_next   = 5'b00000;
          busy_next  = 1'b0;
          state_next = GAP;
        end else if (cnt == 8'(TIMEOUT)) begin
          gnt_next          = 5'b00000;
          busy_next         = 1'b0;
          mask_next[gnt_id] = 1'b1;
          timeout_err_next  = 1'b1;
          state_next        = GAP;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        gnt_next   = 5'b00000;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      mask        <= 5'd0;
      cnt         <= 8'd0;
      gnt         <= 5'd0;
      gnt_id      <= 3'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      mask        <= mask_next;
      cnt         <= cnt_next;
      gnt         <= gnt_next;
      gnt_id      <= gnt_id_next;
      busy        <= busy_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_port_arbiter5.sv
// ---------------------------------------------------------------------------
// tb_port_arbiter5
//
// Testbench for port_arbiter5 with TIMEOUT=4. Directed steps are followed by
// randomized request traffic. A behavioural model tracks the current owner,
// the next priority index, the owned-cycle count and the set of blocked
// masters. Outputs are compared against that model one time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_port_arbiter5;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  // Model of the arbiter. An owner of -1 means the port is free.
  int         m_owner;
  int         m_ptr;
  int         m_cnt;
  logic [4:0] m_blocked;
  logic       m_err;

  always #5 clk = ~clk;

  port_arbiter5 #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // Stops a run that has lost track of the clock.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_cnt     = 0;
    m_blocked = 5'd0;
    m_err     = 1'b0;
  endfunction

  // One rising edge of the model. A free port is handed to the first
  // unblocked requester at or after the priority index. Because a release
  // leaves the port free for one edge, the gap cycle follows automatically.
  function automatic void model_edge(input logic [4:0] r);
    logic [4:0] blocked_after;
    int         winner;
    int         j;
    m_err         = 1'b0;
    blocked_after = m_blocked & r;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_cnt == T) begin
        blocked_after[m_owner] = 1'b1;
        m_err   = 1'b1;
        m_owner = -1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      winner = -1;
      for (int k = 0; k < 5; k++) begin
        j = (m_ptr + k) % 5;
        if (winner < 0 && r[j] && !m_blocked[j]) winner = j;
      end
      if (winner >= 0) begin
        m_owner = winner;
        m_ptr   = (winner + 1) % 5;
        m_cnt   = 1;
      end
    end
    m_blocked = blocked_after;
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [4:0] eg;
    logic       eb;
    eg = (m_owner >= 0) ? 5'(1 << m_owner) : 5'd0;
    eb = (m_owner >= 0);
    checks++;
    assert (gnt === eg) else begin
      failures++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
    end
    checks++;
    assert (busy === eb) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, eb);
    end
    checks++;
    assert (timeout_err === m_err) else begin
      failures++;
      $error("[TB] FAIL %s timeout_err observed=%b expected=%b", tag, timeout_err, m_err);
    end
    if (m_owner >= 0) begin
      checks++;
      assert (gnt_id === 3'(m_owner)) else begin
        failures++;
        $error("[TB] FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, m_owner);
      end
    end
  endtask

  // Drives req at the falling edge and advances the model at the rising
  // edge. Outputs are then checked one time unit later.
  task automatic applyStimulus(input logic [4:0] r, input string tag);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [4:0] rq;

    // Reset held with every master requesting.
    reset_n = 1'b0;
    req     = 5'h1F;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkValue("rst_gnt", 8'(gnt), 8'h00);
    checkValue("rst_busy", 8'(busy), 8'h00);
    checkValue("rst_err", 8'(timeout_err), 8'h00);
    #2 reset_n = 1'b1;
    applyStimulus(5'h1F, "rst_release");
    checkValue("rst_first_gnt", 8'(gnt), 8'h01);

    // Round robin. Each owner keeps the port for 3 cycles, drops for one
    // edge, then re-raises.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'h1F, "rr_hold");
      applyStimulus(5'h1F, "rr_hold");
      applyStimulus(5'h1F & ~5'(1 << i), "rr_drop");
      checkValue("rr_gap", 8'(gnt), 8'h00);
      applyStimulus(5'h1F, "rr_next");
      checkValue("rr_order", 8'(gnt), 8'(1 << ((i + 1) % 5)));
    end
    applyStimulus(5'h00, "rr_end");
    applyStimulus(5'h00, "rr_idle");

    // Give master 1 one grant. This leaves the priority index at 2.
    applyStimulus(5'h02, "pre_skip");
    applyStimulus(5'h00, "pre_skip_rel");
    applyStimulus(5'h00, "pre_skip_idle");

    // Pointer skip. Only masters 3 and 1 request while the index is 2.
    applyStimulus(5'h0A, "skip_grant");
    checkValue("skip_gnt3", 8'(gnt), 8'h08);
    checkValue("skip_id3", 8'(gnt_id), 8'h03);
    applyStimulus(5'h02, "skip_rel");
    applyStimulus(5'h02, "skip_next");
    checkValue("skip_gnt1", 8'(gnt), 8'h02);
    applyStimulus(5'h00, "skip_end");
    applyStimulus(5'h00, "skip_idle");

    // Timeout. Master 2 holds its request; master 0 also requests.
    applyStimulus(5'h05, "to_grant");
    checkValue("to_gnt2", 8'(gnt), 8'h04);
    for (int c = 0; c < T - 1; c++) begin
      applyStimulus(5'h05, "to_hold");
      checkValue("to_held", 8'(gnt), 8'h04);
    end
    applyStimulus(5'h05, "to_revoke");
    checkValue("to_err", 8'(timeout_err), 8'h01);
    checkValue("to_gap", 8'(gnt), 8'h00);
    applyStimulus(5'h05, "to_other");
    checkValue("to_gnt0", 8'(gnt), 8'h01);
    applyStimulus(5'h05, "to_hold0");
    applyStimulus(5'h04, "to_rel0");
    applyStimulus(5'h04, "to_masked");
    checkValue("to_masked_gnt", 8'(gnt), 8'h00);
    applyStimulus(5'h04, "to_masked2");
    checkValue("to_masked_gnt2", 8'(gnt), 8'h00);
    applyStimulus(5'h00, "to_unmask");
    applyStimulus(5'h04, "to_regrant");
    checkValue("to_regrant_gnt", 8'(gnt), 8'h04);

    // Request drop on the same edge that the count reaches TIMEOUT.
    for (int c = 0; c < T - 1; c++) applyStimulus(5'h04, "sim_hold");
    applyStimulus(5'h00, "sim_drop");
    checkValue("sim_no_err", 8'(timeout_err), 8'h00);
    checkValue("sim_gap", 8'(gnt), 8'h00);
    applyStimulus(5'h04, "sim_regrant");
    checkValue("sim_not_masked", 8'(gnt), 8'h04);

    // Reset pulse in the middle of an owned cycle.
    applyStimulus(5'h04, "mid_own");
    #2;
    reset_n = 1'b0;
    req     = 5'h10;
    #1;
    checkValue("mid_rst_gnt", 8'(gnt), 8'h00);
    checkValue("mid_rst_busy", 8'(busy), 8'h00);
    model_reset();
    reset_n = 1'b1;
    applyStimulus(5'h10, "mid_release");
    checkValue("mid_gnt4", 8'(gnt), 8'h10);

    // Random request traffic. Each line toggles with probability 1/6 per
    // cycle, so grants run into the timeout regularly.
    rq = 5'h10;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      applyStimulus(rq, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
